// File: rtl/uart_cpu_mul_pkg.sv
// Shared widths, slot-state encoding and partial-product combine helpers
// for the Nios II multiplier M-stage consumer.
package uart_cpu_mul_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PEND  = 2'd1,
    FULL  = 2'd2
  } slot_state_t;

  // Only the low halves of the cross partials reach the low 32 product bits.
  function automatic logic [HALF_W-1:0] mid_sum(input logic [DATA_W-1:0] p2,
                                                input logic [DATA_W-1:0] p3);
    logic [DATA_W-1:0] w_sum;
    w_sum = p2 + p3;
    return w_sum[HALF_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] place_mid(input logic [DATA_W-1:0] p1,
                                                  input logic [HALF_W-1:0] mid);
    return p1 + {mid, {HALF_W{1'b0}}};
  endfunction

  function automatic logic [DATA_W-1:0] mul_combine(input logic [DATA_W-1:0] p1,
                                                    input logic [DATA_W-1:0] p2,
                                                    input logic [DATA_W-1:0] p3);
    return place_mid(p1, mid_sum(p2, p3));
  endfunction

endpackage

// File: rtl/uart_cpu_mul_combine_if.sv
// Result handshake bundle. A product transfers on any edge where res_valid and
// res_ready are both 1; the master holds res_data stable while res_valid & ~res_ready.
interface uart_cpu_mul_combine_if #(
  parameter int DATA_W = uart_cpu_mul_pkg::DATA_W
);
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  modport master (output res_valid, output res_data, input res_ready);
  modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/uart_cpu_mul_result_buf.sv
// One-entry result hold register: loads on in_valid & in_ready, overwrites in
// place when the held product is accepted on the same edge.
module uart_cpu_mul_result_buf (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_valid,
  input  logic [uart_cpu_mul_pkg::DATA_W-1:0] i_data,
  output logic                          o_ready,
  output logic                          o_block,
  output uart_cpu_mul_pkg::slot_state_t o_dbg_state,
  uart_cpu_mul_combine_if.master        res_if
);
  import uart_cpu_mul_pkg::*;

  slot_state_t       r_state;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_load;

  assign o_ready          = ~r_valid | res_if.res_ready;
  assign w_load           = i_valid & o_ready;
  assign o_block          = r_valid & ~res_if.res_ready;
  assign o_dbg_state      = r_state;
  assign res_if.res_valid = r_valid;
  assign res_if.res_data  = r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_load) begin
            r_state <= FULL;
            r_valid <= 1'b1;
            r_data  <= i_data;
          end
        end
        FULL: begin
          if (w_load) begin
            r_data <= i_data;
          end else if (res_if.res_ready) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_cpu_mul_combine.sv
// M-stage consumer of the 3-partial multiplier cell: tracks issue, combines partials
// into the low 32-bit product and buffers it. UART_CPU_MUL_COMBINE_PIPE_EN adds a stage.
module uart_cpu_mul_combine #(
  parameter int DATA_W = 32,
  parameter int HALF_W = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          mul_start,
  input  logic                          M_en,
  input  logic [DATA_W-1:0]             M_mul_cell_p1,
  input  logic [DATA_W-1:0]             M_mul_cell_p2,
  input  logic [DATA_W-1:0]             M_mul_cell_p3,
  output logic                          mul_stall,
  output logic                          proto_err,
  output uart_cpu_mul_pkg::slot_state_t dbg_pend_state,
  output uart_cpu_mul_pkg::slot_state_t dbg_buf_state,
  uart_cpu_mul_combine_if.master        res_if
);
  import uart_cpu_mul_pkg::*;

  generate
    if (DATA_W != 32 || HALF_W != DATA_W / 2) begin : g_bad_cfg
      $error("uart_cpu_mul_combine supports only DATA_W=32, HALF_W=16");
    end
  endgenerate

  slot_state_t       r_pend_state;
  logic              r_proto_err;
  logic              w_accept_start;
  logic              w_pend_adv;
  logic              w_buf_in_valid;
  logic [DATA_W-1:0] w_buf_in_data;
  logic              w_buf_in_ready;
  logic              w_block;

  assign w_accept_start = mul_start & M_en & ~mul_stall;
  assign proto_err      = r_proto_err;
  assign dbg_pend_state = r_pend_state;

  // PEND means the cell registers hold this product's partials; a stuck PEND
  // always coincides with mul_stall, so upstream keeps M_en low and the cell holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_state <= EMPTY;
    end else begin
      case (r_pend_state)
        EMPTY: if (w_accept_start) r_pend_state <= PEND;
        PEND:  if (w_pend_adv)     r_pend_state <= w_accept_start ? PEND : EMPTY;
        default: r_pend_state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_proto_err <= 1'b0;
    end else if (mul_start & (mul_stall | ~M_en)) begin
      r_proto_err <= 1'b1;
    end
  end

`ifdef UART_CPU_MUL_COMBINE_PIPE_EN
  slot_state_t       r_s1_state;
  logic [DATA_W-1:0] r_s1_p1;
  logic [HALF_W-1:0] r_s1_mid;
  logic              w_s1_full;

  assign w_s1_full      = (r_s1_state == FULL);
  assign w_pend_adv     = (r_pend_state == PEND) & (~w_s1_full | w_buf_in_ready);
  assign w_buf_in_valid = w_s1_full;
  assign w_buf_in_data  = place_mid(r_s1_p1, r_s1_mid);
  assign mul_stall      = w_block & (w_s1_full | (r_pend_state == PEND));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_state <= EMPTY;
      r_s1_p1    <= '0;
      r_s1_mid   <= '0;
    end else if (w_pend_adv) begin
      r_s1_state <= FULL;
      r_s1_p1    <= M_mul_cell_p1;
      r_s1_mid   <= mid_sum(M_mul_cell_p2, M_mul_cell_p3);
    end else if (w_s1_full & w_buf_in_ready) begin
      r_s1_state <= EMPTY;
    end
  end
`else
  assign w_pend_adv     = (r_pend_state == PEND) & w_buf_in_ready;
  assign w_buf_in_valid = (r_pend_state == PEND);
  assign w_buf_in_data  = mul_combine(M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3);
  assign mul_stall      = w_block;
`endif

  uart_cpu_mul_result_buf u_result_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_valid     (w_buf_in_valid),
    .i_data      (w_buf_in_data),
    .o_ready     (w_buf_in_ready),
    .o_block     (w_block),
    .o_dbg_state (dbg_buf_state),
    .res_if      (res_if)
  );

endmodule

// File: tb/tb_uart_cpu_mul_combine.sv
// Directed bench for uart_cpu_mul_combine: vector table for single products plus
// sequences for back-to-back issue, backpressure, protocol errors and reset.
module tb_uart_cpu_mul_combine;
  import uart_cpu_mul_pkg::*;

`ifdef UART_CPU_MUL_COMBINE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mul_start;
  logic        M_en;
  logic [31:0] src1, src2;
  logic [31:0] p1, p2, p3;
  logic        mul_stall;
  logic        proto_err;
  slot_state_t dbg_pend_state, dbg_buf_state;

  uart_cpu_mul_combine_if res_if ();

  uart_cpu_mul_combine dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mul_start      (mul_start),
    .M_en           (M_en),
    .M_mul_cell_p1  (p1),
    .M_mul_cell_p2  (p2),
    .M_mul_cell_p3  (p3),
    .mul_stall      (mul_stall),
    .proto_err      (proto_err),
    .dbg_pend_state (dbg_pend_state),
    .dbg_buf_state  (dbg_buf_state),
    .res_if         (res_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  // multiplier cell model: registers the three partials whenever M_en is high
  always @(posedge clk) begin
    if (M_en) begin
      p1 <= {16'h0, src1[15:0]} * {16'h0, src2[15:0]};
      p2 <= {16'h0, src1[15:0]} * {16'h0, src2[31:16]};
      p3 <= {16'h0, src1[31:16]} * {16'h0, src2[15:0]};
    end
  end

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    mul_start        = 1'b0;
    M_en             = 1'b1;
    res_if.res_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 8 && !res_if.res_valid; k++) tick();
    check(name, 32'(res_if.res_valid), 32'd1);
  endtask

  task automatic count_idle(input string name, input int cycles);
    int nv;
    nv = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (res_if.res_valid) nv++;
    end
    check(name, 32'(nv), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, last, nvalid, stall_seen;

    vecs[0] = '{32'h0001_2345, 32'h0000_0010, 32'h0012_3450};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};
    vecs[4] = '{32'h0000_0003, 32'h8000_0000, 32'h8000_0000};
    vecs[5] = '{32'h0002_0003, 32'h0004_0005, 32'h0016_000F};
    vecs[6] = '{32'h0000_FFFF, 32'hFFFF_0000, 32'h0001_0000};

    src1 = '0;
    src2 = '0;
    do_reset();
    check("rst_valid", 32'(res_if.res_valid), 32'd0);
    check("rst_data", res_if.res_data, 32'd0);
    check("rst_stall", 32'(mul_stall), 32'd0);
    check("rst_proto", 32'(proto_err), 32'd0);

    // table: single products, consumer always ready, exact latency
    for (int i = 0; i < 7; i++) begin
      src1 = vecs[i].src1;
      src2 = vecs[i].src2;
      mul_start = 1'b1;
      tick();
      mul_start = 1'b0;
      for (int k = 1; k < LAT; k++) begin
        check("vec_early", 32'(res_if.res_valid), 32'd0);
        tick();
      end
      check("vec_valid", 32'(res_if.res_valid), 32'd1);
      check("vec_data", res_if.res_data, vecs[i].exp);
      tick();
      check("vec_drain", 32'(res_if.res_valid), 32'd0);
    end

    // four back-to-back starts, consumer ready
    first = -1; last = -1; nvalid = 0; stall_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        src1 = vecs[c].src1;
        src2 = vecs[c].src2;
        mul_start = 1'b1;
        exp_q.push_back(vecs[c].exp);
      end else begin
        mul_start = 1'b0;
      end
      if (mul_stall) stall_seen = 1;
      tick();
      if (res_if.res_valid) begin
        nvalid++;
        if (first < 0) first = c;
        last = c;
        if (exp_q.size() > 0) check("b2b_data", res_if.res_data, exp_q.pop_front());
        else check("b2b_extra", res_if.res_data, 32'hDEAD_BEEF ^ res_if.res_data);
      end
    end
    check("b2b_count", 32'(nvalid), 32'd4);
    check("b2b_contig", 32'(last - first), 32'd3);
    check("b2b_nostall", 32'(stall_seen), 32'd0);

    // backpressure: one product held, one waiting behind it
    res_if.res_ready = 1'b0;
    src1 = vecs[5].src1; src2 = vecs[5].src2; mul_start = 1'b1;
    exp_q.push_back(vecs[5].exp);
    tick();
    src1 = vecs[6].src1; src2 = vecs[6].src2;
    exp_q.push_back(vecs[6].exp);
    tick();
    mul_start = 1'b0;
    M_en = 1'b0;
    wait_valid("hold_wait");
    for (int k = 0; k < 5; k++) begin
      check("hold_stall", 32'(mul_stall), 32'd1);
      check("hold_data", res_if.res_data, exp_q[0]);
      tick();
    end
    check("hold_bufstate", 32'(dbg_buf_state), 32'(FULL));
    res_if.res_ready = 1'b1;
    check("hold_release", res_if.res_data, exp_q.pop_front());
    tick();
    check("hold_next_valid", 32'(res_if.res_valid), 32'd1);
    check("hold_next_data", res_if.res_data, exp_q.pop_front());
    tick();
    check("hold_drain", 32'(res_if.res_valid), 32'd0);
    M_en = 1'b1;
    count_idle("hold_nodup", 4);

    // start while stalled: ignored and flagged
    res_if.res_ready = 1'b0;
    src1 = vecs[0].src1; src2 = vecs[0].src2; mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    M_en = 1'b0;
    wait_valid("perr_wait");
    check("perr_stall", 32'(mul_stall), 32'd1);
    check("perr_clean", 32'(proto_err), 32'd0);
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    check("perr_set", 32'(proto_err), 32'd1);
    res_if.res_ready = 1'b1;
    check("perr_data", res_if.res_data, vecs[0].exp);
    tick();
    M_en = 1'b1;
    count_idle("perr_noprod", 6);
    check("perr_sticky", 32'(proto_err), 32'd1);

    // start with M_en low: ignored and flagged
    do_reset();
    check("men_clean", 32'(proto_err), 32'd0);
    M_en = 1'b0;
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    M_en = 1'b1;
    check("men_perr", 32'(proto_err), 32'd1);
    count_idle("men_noprod", 5);

    // reset with both pending and buffered products
    do_reset();
    res_if.res_ready = 1'b0;
    src1 = vecs[1].src1; src2 = vecs[1].src2; mul_start = 1'b1;
    tick();
    src1 = vecs[2].src1; src2 = vecs[2].src2;
    tick();
    mul_start = 1'b0;
    M_en = 1'b0;
    wait_valid("rstocc_wait");
    reset_n = 1'b0;
    #1;
    check("rstocc_valid", 32'(res_if.res_valid), 32'd0);
    check("rstocc_data", res_if.res_data, 32'd0);
    check("rstocc_pend", 32'(dbg_pend_state), 32'(EMPTY));
    tick();
    reset_n = 1'b1;
    M_en = 1'b1;
    res_if.res_ready = 1'b1;
    count_idle("rstocc_noprod", 8);
    check("rstocc_perr", 32'(proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
